// File: rtl/uart_receive_if.sv
// Receiver-side signal bundle: serial line and consumer strobe in,
// received byte plus status out.
interface uart_receive_if;
    logic       rx;
    logic       data_ack;
    logic [7:0] data_byte;
    logic       data_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx, data_ack,
        input  data_byte, data_valid, overrun, frame_err, busy
    );

    modport slave (
        input  rx, data_ack,
        output data_byte, data_valid, overrun, frame_err, busy
    );
endinterface

// File: rtl/uart_receive.sv
// 8N1 UART receiver: mid-bit sampling from a single bit-period down-counter,
// one-byte holding register with consumer acknowledge and sticky overrun.
module uart_receive #(
    parameter int BAUD_RATE = 9600,
    parameter int CLK_MHZ   = 100
) (
    input logic           clk,
    input logic           reset,
    uart_receive_if.slave bus
);
    localparam int BIT_CYC  = CLK_MHZ * 1000000 / BAUD_RATE;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC + 1);

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    logic             rx_p0;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             frame_err_r;
    logic [7:0]       data_byte_r;
    logic             data_valid_r;
    logic             overrun_r;
    logic             cnt_done;
    logic             commit;

    assign cnt_done = (cnt == '0);
    assign commit   = (state == ST_STOP) && cnt_done && rx_s;

    // --- synchronizer and framing FSM ---
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_p0       <= 1'b1;
            rx_s        <= 1'b1;
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            frame_err_r <= 1'b0;
        end else begin
            rx_p0       <= bus.rx;
            rx_s        <= rx_p0;
            frame_err_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (cnt_done) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        if (!rx_s) begin
                            state <= ST_DATA;
                            cnt   <= BIT_LOAD;
                            idx   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_done) begin
                        shreg[idx] <= rx_s;
                        cnt        <= BIT_LOAD;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7)
                            state <= ST_STOP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_done) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state       <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_WAIT_IDLE: begin
                    // Line break: wait for the line to return high before rearming.
                    if (rx_s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // --- holding register and consumer handshake ---
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_byte_r  <= '0;
            data_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (commit) begin
            data_byte_r  <= shreg;
            data_valid_r <= 1'b1;
            if (data_valid_r && !bus.data_ack)
                overrun_r <= 1'b1;
        end else if (bus.data_ack) begin
            data_valid_r <= 1'b0;
        end
    end

    assign bus.data_byte  = data_byte_r;
    assign bus.data_valid = data_valid_r;
    assign bus.overrun    = overrun_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive at a reduced bit period (16 clocks per bit) with a
// byte scoreboard fed by the frame driver and drained by a commit monitor.
module tb_uart_receive;
    localparam int CLK_MHZ   = 1;
    localparam int BAUD      = 62500;
    localparam int BIT       = 16;
    localparam int HALF      = 8;
    // Clock edge (counted from the negedge that drives the start bit) that samples the stop bit.
    localparam int STOP_EDGE = 2 + HALF + 9 * BIT;

    logic clk = 1'b0;
    logic reset;
    uart_receive_if bus();

    uart_receive #(.BAUD_RATE(BAUD), .CLK_MHZ(CLK_MHZ)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_ferr;
        logic       exp_valid;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t       vecs[5];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         ferr_cnt = 0;
    logic       busy_seen = 1'b0;
    logic       dv_at_stop, dv_after_stop, dv_low_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input logic stop_bit, input int c);
        int b;
        b = c / BIT;
        if (b == 0)      return 1'b0;
        else if (b <= 8) return d[b-1];
        else             return stop_bit;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int ack_at);
        if (stop_bit) exp_q.push_back(d);
        dv_low_seen = 1'b0;
        for (int c = 0; c < 10 * BIT; c++) begin
            @(negedge clk);
            if (c == STOP_EDGE)     dv_at_stop    = bus.data_valid;
            if (c == STOP_EDGE + 1) dv_after_stop = bus.data_valid;
            if (c >= STOP_EDGE - 4 && !bus.data_valid) dv_low_seen = 1'b1;
            bus.rx       = frame_bit(d, stop_bit, c);
            bus.data_ack = (c == ack_at);
        end
        @(negedge clk);
        bus.data_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        bus.data_ack = 1'b1;
        @(negedge clk);
        bus.data_ack = 1'b0;
    endtask

    // Commit monitor: a new byte shows as data_valid rising or data_byte changing while valid.
    logic [7:0] prev_byte  = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_byte  = 8'h00;
            prev_valid = 1'b0;
            prev_ferr  = 1'b0;
        end else begin
            if (bus.data_valid && (!prev_valid || bus.data_byte != prev_byte)) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_commit: got 0x%0h, expected no commit", bus.data_byte);
                end else begin
                    chk("commit_byte", {24'h0, bus.data_byte}, {24'h0, exp_q.pop_front()});
                end
            end
            if (bus.frame_err) begin
                ferr_cnt++;
                chk("frame_err_one_cycle", {31'h0, prev_ferr}, 32'h0);
            end
            if (bus.busy) busy_seen = 1'b1;
            prev_byte  = bus.data_byte;
            prev_valid = bus.data_valid;
            prev_ferr  = bus.frame_err;
        end
    end

    initial begin
        vecs[0] = '{d: 8'hA5, stop: 1'b1, exp_ferr: 0, exp_valid: 1'b1, exp_byte: 8'hA5};
        vecs[1] = '{d: 8'h01, stop: 1'b1, exp_ferr: 0, exp_valid: 1'b1, exp_byte: 8'h01};
        vecs[2] = '{d: 8'hC3, stop: 1'b0, exp_ferr: 1, exp_valid: 1'b0, exp_byte: 8'h01};
        vecs[3] = '{d: 8'h80, stop: 1'b1, exp_ferr: 0, exp_valid: 1'b1, exp_byte: 8'h80};
        vecs[4] = '{d: 8'h7E, stop: 1'b1, exp_ferr: 0, exp_valid: 1'b1, exp_byte: 8'h7E};

        bus.rx       = 1'b1;
        bus.data_ack = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data_byte", {24'h0, bus.data_byte}, 32'h0);
        chk("reset_data_valid", {31'h0, bus.data_valid}, 32'h0);
        chk("reset_overrun", {31'h0, bus.overrun}, 32'h0);
        chk("reset_frame_err", {31'h0, bus.frame_err}, 32'h0);
        chk("reset_busy", {31'h0, bus.busy}, 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven frames, each acknowledged after reception.
        for (int i = 0; i < 5; i++) begin
            ferr_cnt = 0;
            send_frame(vecs[i].d, vecs[i].stop, -1);
            if (i == 0) begin
                chk("latency_before_stop", {31'h0, dv_at_stop}, 32'h0);
                chk("latency_at_stop", {31'h0, dv_after_stop}, 32'h1);
            end
            chk("vec_frame_err", ferr_cnt, vecs[i].exp_ferr);
            chk("vec_data_valid", {31'h0, bus.data_valid}, {31'h0, vecs[i].exp_valid});
            chk("vec_data_byte", {24'h0, bus.data_byte}, {24'h0, vecs[i].exp_byte});
            ack_pulse();
            chk("vec_ack_clears", {31'h0, bus.data_valid}, 32'h0);
            bus.rx = 1'b1;
            repeat (4) @(negedge clk);
        end
        ack_pulse();
        chk("idle_ack_ignored_valid", {31'h0, bus.data_valid}, 32'h0);
        chk("idle_ack_overrun", {31'h0, bus.overrun}, 32'h0);

        // Start-bit glitch shorter than half a bit.
        ferr_cnt  = 0;
        busy_seen = 1'b0;
        bus.rx    = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_busy_pulsed", {31'h0, busy_seen}, 32'h1);
        chk("glitch_busy_idle", {31'h0, bus.busy}, 32'h0);
        chk("glitch_data_valid", {31'h0, bus.data_valid}, 32'h0);
        chk("glitch_frame_err", ferr_cnt, 0);

        // Bad stop bit followed by a line break, then a clean frame.
        ferr_cnt = 0;
        send_frame(8'h3C, 1'b0, -1);
        repeat (3 * BIT) @(negedge clk);
        chk("break_frame_err", ferr_cnt, 1);
        chk("break_data_valid", {31'h0, bus.data_valid}, 32'h0);
        chk("break_busy_held", {31'h0, bus.busy}, 32'h1);
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("break_busy_released", {31'h0, bus.busy}, 32'h0);
        send_frame(8'h5A, 1'b1, -1);
        chk("after_break_byte", {24'h0, bus.data_byte}, 32'h5A);
        chk("after_break_valid", {31'h0, bus.data_valid}, 32'h1);
        ack_pulse();

        // Overrun, then acknowledge in the same cycle as the third commit.
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        chk("overrun_byte", {24'h0, bus.data_byte}, 32'h22);
        chk("overrun_valid", {31'h0, bus.data_valid}, 32'h1);
        chk("overrun_flag", {31'h0, bus.overrun}, 32'h1);
        send_frame(8'h33, 1'b1, STOP_EDGE);
        chk("ack_commit_no_drop", {31'h0, dv_low_seen}, 32'h0);
        chk("ack_commit_valid", {31'h0, bus.data_valid}, 32'h1);
        chk("ack_commit_byte", {24'h0, bus.data_byte}, 32'h33);
        chk("ack_commit_overrun", {31'h0, bus.overrun}, 32'h1);
        ack_pulse();

        // Reset in the middle of data bit 4 of 0xFF.
        for (int c = 0; c < 5 * BIT + 8; c++) begin
            @(negedge clk);
            bus.rx = frame_bit(8'hFF, 1'b1, c);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_data_byte", {24'h0, bus.data_byte}, 32'h0);
        chk("midreset_data_valid", {31'h0, bus.data_valid}, 32'h0);
        chk("midreset_overrun", {31'h0, bus.overrun}, 32'h0);
        chk("midreset_frame_err", {31'h0, bus.frame_err}, 32'h0);
        chk("midreset_busy", {31'h0, bus.busy}, 32'h0);
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("postreset_busy", {31'h0, bus.busy}, 32'h0);
        send_frame(8'h81, 1'b1, -1);
        chk("postreset_byte", {24'h0, bus.data_byte}, 32'h81);
        chk("postreset_valid", {31'h0, bus.data_valid}, 32'h1);
        ack_pulse();

        // Back-to-back frames, each acknowledged during the next start bit.
        ferr_cnt = 0;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, 2);
        send_frame(8'h55, 1'b1, 2);
        chk("b2b_last_byte", {24'h0, bus.data_byte}, 32'h55);
        ack_pulse();
        chk("b2b_overrun", {31'h0, bus.overrun}, 32'h0);
        chk("b2b_valid_cleared", {31'h0, bus.data_valid}, 32'h0);
        chk("b2b_frame_err", ferr_cnt, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_receive.md
UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 Parameter BAUD_RATE, default 9600, serial bit rate in bits/s.
REQ-002 Parameter CLK_MHZ, default 100, clk frequency in MHz.
REQ-003 Port clk  input  1  system clock; all state on rising edge; only clock.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 Port data_ack  input  1  consumer strobe; clears data_valid.
REQ-007 Port data_byte  output  8  last correctly framed received byte.
REQ-008 Port data_valid  output  1  level; high while data_byte holds an unconsumed byte.
REQ-009 Port overrun  output  1  sticky; a byte was overwritten before ack.
REQ-010 Port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 Port busy  output  1  high in any state other than IDLE.

Function
REQ-012 Frame is 8N1: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-013 BIT_CYC = CLK_MHZ*1000000/BAUD_RATE, truncated integer (10416 at defaults); HALF_CYC = BIT_CYC/2 (5208).
REQ-014 rx passes a two-flop synchronizer, reset value 1; all decisions use the synchronized signal rx_s.
REQ-015 States IDLE, START, DATA, STOP, WAIT_IDLE; one bit-period down-counter; 3-bit bit index.
REQ-016 IDLE: rx_s = 0 -> START, counter loaded with HALF_CYC-1.
REQ-017 START: at counter 0 sample rx_s; 0 -> DATA with counter BIT_CYC-1, index 0; 1 -> IDLE, glitch ignored, no outputs change.
REQ-018 DATA: at each counter 0 shift rx_s into bit[index], reload BIT_CYC-1; after index 7 -> STOP.
REQ-019 STOP: at counter 0 sample rx_s; 1 -> commit byte, -> IDLE; 0 -> frame_err pulse, byte discarded, -> WAIT_IDLE.
REQ-020 WAIT_IDLE: stay until rx_s = 1, then IDLE; holds line breaks without spurious frames.
REQ-021 Commit: data_byte <= shift register, data_valid <= 1, on the edge after the stop sample; ~9.5 bit periods (98952 clk at defaults, +2 sync, +/-1) after the start falling edge.
REQ-022 data_ack while data_valid=1 and no commit that cycle -> data_valid 0 next cycle; data_ack while data_valid=0 ignored.
REQ-023 Commit while data_valid=1 and no data_ack same cycle -> overwrite data_byte, set overrun.
REQ-024 Commit and data_ack same cycle -> new byte loaded, data_valid stays 1, overrun unchanged.
REQ-025 overrun clears only on reset.
REQ-026 data_byte changes only on commit; stable while data_valid=1 otherwise.
REQ-027 Back-to-back frames: start bit immediately following stop-bit sample accepted with no lost byte.

Reset
REQ-028 Reset asserted: state IDLE, counter/index 0, shift register 0, synchronizer 1, data_byte 0x00, data_valid 0, overrun 0, frame_err 0, busy 0.
REQ-029 Reset mid-frame abandons frame; after release, receiver requires a new falling edge on rx_s.

Verification
REQ-030 Defaults, drive 0xA5 at 9600 baud -> data_valid rises ~98954 clk after start edge, data_byte 0xA5, frame_err 0; ack -> data_valid 0 next cycle.
REQ-031 rx low 1000 clk then high -> returns to IDLE, data_valid 0, busy pulses only.
REQ-032 Drive 0x3C with stop bit 0, hold rx low 3 bit times -> frame_err one-cycle pulse, data_valid 0, busy until rx high; next frame 0x5A received correctly.
REQ-033 Send 0x11 then 0x22 without ack -> data_byte 0x22, data_valid 1, overrun 1; ack in commit cycle of a third byte 0x33 -> data_valid stays 1, data_byte 0x33.
REQ-034 Assert reset during data bit 4 of 0xFF -> all outputs at reset values; following 0x81 received as 0x81.
REQ-035 Back-to-back 0x00, 0xFF, 0x55 with ack after each -> three commits, values in order, overrun 0.
